rr_arb4_dec: RTL and testbench

RR_ARB4_DEC -- requirements
Module: rr_arb4_dec

---
 rtl/rr_arb4_dec.sv | 112 +++++++++++
 tb/tb_rr_arb4_dec.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_dec.sv
// rr_arb4_dec: 4-way round-robin arbiter with a hold limit and a decoded grant.
//   clk     : the single clock. All state changes on its rising edge.
//   rst_n   : synchronous active-low reset.
//   req     : request lines. req[k] high means requester k wants the resource.
//   gnt     : registered one-hot grant, or 4'b0000 when nothing is granted.
//   gnt_idx : binary index of the current owner. It holds its value while idle.
//   gnt_vld : high exactly when gnt is non-zero.
//   tmo     : one-cycle pulse on a release forced by MAX_HOLD expiry.
// A grant is issued one edge after the request is seen.
// The owner keeps the grant while it requests, for at most MAX_HOLD cycles.
// Every release passes through IDLE, so at least one gnt=0 cycle separates grants.
module rr_arb4_dec #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       tmo
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          vld_q, vld_d;
  logic          tmo_q, tmo_d;

  logic [1:0]    win;
  logic          win_found;

  // Rotating priority search: ptr is tried first. The 2-bit sum wraps 3->0.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!win_found && req[ptr_q + 2'(i)]) begin
        win       = ptr_q + 2'(i);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win;
          cnt_d   = CW'(1);
          gnt_d   = 4'b0001 << win;
          vld_d   = 1'b1;
        end
      end
      GRANT: begin
        // Only the owner's request line matters here. The other lines are ignored.
        if (req[idx_q] && (cnt_q < MAX_C)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // On release the owner gets the lowest priority. tmo flags a forced release.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 2'd1;
          cnt_d   = '0;
          tmo_d   = req[idx_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'b00;
      idx_q   <= 2'b00;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arb4_dec.sv
module tb_rr_arb4_dec;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req2, req8;
  logic [3:0] gnt2, gnt8;
  logic [1:0] idx2, idx8;
  logic       vld2, vld8, tmo2, tmo8;

  rr_arb4_dec #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .gnt(gnt2), .gnt_idx(idx2),
    .gnt_vld(vld2), .tmo(tmo2));
  rr_arb4_dec #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .gnt(gnt8), .gnt_idx(idx8),
    .gnt_vld(vld8), .tmo(tmo8));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, indexed 0 for MAX_HOLD=2 and 1 for MAX_HOLD=8.
  // owner is -1 when nothing is granted.
  int m_hold_max[2] = '{2, 8};
  int m_owner[2], m_held[2], m_ptr[2], m_idx[2];
  bit m_tmo[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input int m, input bit rst, input logic [3:0] r);
    if (!rst) begin
      m_owner[m] = -1; m_held[m] = 0; m_ptr[m] = 0; m_idx[m] = 0; m_tmo[m] = 0;
    end else if (m_owner[m] < 0) begin
      m_tmo[m] = 0;
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_ptr[m] + i) % 4;
        if (m_owner[m] < 0 && r[k]) begin
          m_owner[m] = k; m_idx[m] = k; m_held[m] = 1;
        end
      end
    end else if (!r[m_owner[m]] || m_held[m] == m_hold_max[m]) begin
      m_tmo[m]   = r[m_owner[m]];
      m_ptr[m]   = (m_owner[m] + 1) % 4;
      m_owner[m] = -1;
    end else begin
      m_held[m]++;
    end
  endtask

  task automatic check_dut(input string tag, input int m, input logic [3:0] g,
                           input logic [1:0] ix, input logic v, input logic t);
    logic [3:0] eg;
    eg = (m_owner[m] < 0) ? 4'b0000 : (4'b0001 << m_owner[m]);
    chk({tag, " gnt"}, 32'(g), 32'(eg));
    chk({tag, " gnt_idx"}, 32'(ix), 32'(m_idx[m]));
    chk({tag, " gnt_vld"}, 32'(v), 32'(m_owner[m] >= 0));
    chk({tag, " tmo"}, 32'(t), 32'(m_tmo[m]));
    chk({tag, " inv onehot0"}, 32'($onehot0(g)), 32'd1);
    chk({tag, " inv vld"}, 32'(v), 32'(|g));
    if (v) chk({tag, " inv decode"}, 32'(g), 32'(4'b0001 << ix));
  endtask

  // Drive the inputs, clock one edge, step the model, then sample 1 ns after the edge.
  task automatic cyc(input bit rst, input logic [3:0] r2, input logic [3:0] r8);
    rst_n = rst; req2 = r2; req8 = r8;
    @(posedge clk);
    model_step(0, rst, r2);
    model_step(1, rst, r8);
    #1;
    check_dut("mh2", 0, gnt2, idx2, vld2, tmo2);
    check_dut("mh8", 1, gnt8, idx8, vld8, tmo8);
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    bit         tmo;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [3:0] r8;
    rst_n = 1'b0; req2 = '0; req8 = '0;

    // Round-robin with MAX_HOLD=2, then wrap-around from ptr=3. Drives dut2 only.
    tbl = '{
      '{0, 4'b0000, 4'b0000, 2'd0, 0},
      '{1, 4'b1111, 4'b0001, 2'd0, 0},
      '{1, 4'b1111, 4'b0001, 2'd0, 0},
      '{1, 4'b1111, 4'b0000, 2'd0, 1},
      '{1, 4'b1111, 4'b0010, 2'd1, 0},
      '{1, 4'b1111, 4'b0010, 2'd1, 0},
      '{1, 4'b1111, 4'b0000, 2'd1, 1},
      '{1, 4'b1111, 4'b0100, 2'd2, 0},
      '{1, 4'b1111, 4'b0100, 2'd2, 0},
      '{1, 4'b1111, 4'b0000, 2'd2, 1},
      '{1, 4'b1111, 4'b1000, 2'd3, 0},
      '{1, 4'b1111, 4'b1000, 2'd3, 0},
      '{1, 4'b1111, 4'b0000, 2'd3, 1},
      '{1, 4'b1111, 4'b0001, 2'd0, 0},
      '{1, 4'b0000, 4'b0000, 2'd0, 0},
      '{1, 4'b0100, 4'b0100, 2'd2, 0},
      '{1, 4'b0000, 4'b0000, 2'd2, 0},
      '{1, 4'b1001, 4'b1000, 2'd3, 0},
      '{1, 4'b1001, 4'b1000, 2'd3, 0},
      '{1, 4'b1001, 4'b0000, 2'd3, 1},
      '{1, 4'b1001, 4'b0001, 2'd0, 0}
    };
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].rst, tbl[i].req, 4'b0000);
      chk($sformatf("tbl[%0d] gnt", i), 32'(gnt2), 32'(tbl[i].gnt));
      chk($sformatf("tbl[%0d] idx", i), 32'(idx2), 32'(tbl[i].idx));
      chk($sformatf("tbl[%0d] tmo", i), 32'(tmo2), 32'(tbl[i].tmo));
      chk($sformatf("tbl[%0d] vld", i), 32'(vld2), 32'(tbl[i].gnt != 0));
    end

    // Single request on dut8.
    cyc(0, 4'b0000, 4'b0000);
    chk("rst gnt", 32'(gnt8), 32'h0);
    chk("rst idx", 32'(idx8), 32'h0);
    chk("rst vld", 32'(vld8), 32'h0);
    chk("rst tmo", 32'(tmo8), 32'h0);
    cyc(1, 4'b0000, 4'b0100);
    chk("single gnt", 32'(gnt8), 32'h4);
    chk("single idx", 32'(idx8), 32'h2);
    chk("single vld", 32'(vld8), 32'h1);
    cyc(1, 4'b0000, 4'b0000);
    chk("single drop gnt", 32'(gnt8), 32'h0);
    chk("single drop idx kept", 32'(idx8), 32'h2);

    // Timeout with MAX_HOLD=8. The grant lasts 8 cycles, then a tmo dead cycle, then a re-grant.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 4'b0000, 4'b0010);
      chk($sformatf("tmo seq %0d gnt", i), 32'(gnt8), ((i % 9) < 8) ? 32'h2 : 32'h0);
      chk($sformatf("tmo seq %0d tmo", i), 32'(tmo8), ((i % 9) == 8) ? 32'h1 : 32'h0);
    end
    cyc(1, 4'b0000, 4'b0000);
    chk("tmo seq release", 32'(gnt8), 32'h0);

    // Reset in the middle of a grant. It must have no effect until the edge.
    cyc(1, 4'b0000, 4'b0100);
    chk("mid gnt", 32'(gnt8), 32'h4);
    rst_n = 1'b0;
    #2;
    chk("rst no async effect", 32'(gnt8), 32'h4);
    cyc(0, 4'b0000, 4'b0100);
    chk("mid rst gnt", 32'(gnt8), 32'h0);
    chk("mid rst idx", 32'(idx8), 32'h0);
    chk("mid rst vld", 32'(vld8), 32'h0);
    chk("mid rst tmo", 32'(tmo8), 32'h0);
    cyc(1, 4'b0000, 4'b0100);
    chk("post rst regrant", 32'(gnt8), 32'h4);
    chk("post rst idx", 32'(idx8), 32'h2);

    // Random traffic with occasional resets. dut8 requests are sticky so that timeouts occur.
    r8 = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) r8 = 4'($urandom);
      cyc($urandom_range(0, 59) != 0, 4'($urandom), r8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
